// File: rtl/rps_score_keeper.sv
// rps_score_keeper
//    Judges Rock-Paper-Scissors rounds, keeps one BCD score digit per player
//    and declares the match winner once a player reaches WIN_SCORE.
//    The scores feed the seven-segment digit decoders directly.
//
// Parameters
//    WIN_SCORE     score that ends the match (1..9, keeps scores one BCD digit)
//
// Build option
//    RPS_TIE_COUNT_EN  when defined, tie_count counts judged ties mod 10;
//                      otherwise tie_count is tied to zero.
//
// Ports
//    clk           system clock, rising edge
//    rst_n         asynchronous active-low reset
//    round_valid   one-cycle strobe, p1_move/p2_move hold a round
//    p1_move       00 none, 01 rock, 10 paper, 11 scissors
//    p2_move       same encoding as p1_move
//    clear_game    synchronous match restart, beats everything but reset
//    busy          high while a round is being judged
//    result_valid  one-cycle pulse when round_result updates
//    round_result  00 none, 01 P1 win, 10 P2 win, 11 tie (held)
//    round_err     one-cycle pulse, round rejected due to a 00 move
//    p1_score      P1 wins, BCD 0..WIN_SCORE
//    p2_score      P2 wins, BCD 0..WIN_SCORE
//    winner        00 none, 01 P1, 10 P2
//    game_over     high once the match is decided
//    tie_count     BCD tie count (zero unless RPS_TIE_COUNT_EN)
//
// State table
//    state  | meaning
//    PLAY   | idle, accepting rounds
//    JUDGE  | one cycle: latched moves are scored
//    OVER   | match decided, waiting for clear_game or reset

module rps_score_keeper #(
   parameter int WIN_SCORE = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       round_valid,
   input  logic [1:0] p1_move,
   input  logic [1:0] p2_move,
   input  logic       clear_game,
   output logic       busy,
   output logic       result_valid,
   output logic [1:0] round_result,
   output logic       round_err,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic [1:0] winner,
   output logic       game_over,
   output logic [3:0] tie_count
);

   localparam logic [1:0] S_PLAY  = 2'd0;
   localparam logic [1:0] S_JUDGE = 2'd1;
   localparam logic [1:0] S_OVER  = 2'd2;

   localparam logic [1:0] MV_NONE     = 2'b00;
   localparam logic [1:0] MV_ROCK     = 2'b01;
   localparam logic [1:0] MV_PAPER    = 2'b10;
   localparam logic [1:0] MV_SCISSORS = 2'b11;

   localparam logic [1:0] RES_NONE = 2'b00;
   localparam logic [1:0] RES_P1   = 2'b01;
   localparam logic [1:0] RES_P2   = 2'b10;
   localparam logic [1:0] RES_TIE  = 2'b11;

   localparam logic [3:0] WIN_BCD = 4'(WIN_SCORE);

   logic [1:0] state;
   logic [1:0] p1_mv;
   logic [1:0] p2_mv;
   logic       p1_beats;
   logic [1:0] judged;
   logic [3:0] p1_next;
   logic [3:0] p2_next;

   assign busy      = (state == S_JUDGE);
   assign game_over = (state == S_OVER);
   assign p1_next   = p1_score + 4'd1;
   assign p2_next   = p2_score + 4'd1;

   always_comb begin
      p1_beats = ((p1_mv == MV_ROCK)     && (p2_mv == MV_SCISSORS)) ||
                 ((p1_mv == MV_SCISSORS) && (p2_mv == MV_PAPER))    ||
                 ((p1_mv == MV_PAPER)    && (p2_mv == MV_ROCK));
      if (p1_mv == p2_mv)
         judged = RES_TIE;
      else if (p1_beats)
         judged = RES_P1;
      else
         judged = RES_P2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_PLAY;
         p1_mv        <= MV_NONE;
         p2_mv        <= MV_NONE;
         result_valid <= 1'b0;
         round_result <= RES_NONE;
         round_err    <= 1'b0;
         p1_score     <= 4'd0;
         p2_score     <= 4'd0;
         winner       <= 2'b00;
      end else begin
         result_valid <= 1'b0;
         round_err    <= 1'b0;
         if (clear_game) begin
            // a pending round in JUDGE is simply dropped
            state        <= S_PLAY;
            round_result <= RES_NONE;
            p1_score     <= 4'd0;
            p2_score     <= 4'd0;
            winner       <= 2'b00;
         end else begin
            case (state)
               S_PLAY: begin
                  if (round_valid) begin
                     if ((p1_move == MV_NONE) || (p2_move == MV_NONE)) begin
                        round_err <= 1'b1;
                     end else begin
                        p1_mv <= p1_move;
                        p2_mv <= p2_move;
                        state <= S_JUDGE;
                     end
                  end
               end
               S_JUDGE: begin
                  result_valid <= 1'b1;
                  round_result <= judged;
                  state        <= S_PLAY;
                  if (judged == RES_P1) begin
                     p1_score <= p1_next;
                     if (p1_next == WIN_BCD) begin
                        state  <= S_OVER;
                        winner <= 2'b01;
                     end
                  end else if (judged == RES_P2) begin
                     p2_score <= p2_next;
                     if (p2_next == WIN_BCD) begin
                        state  <= S_OVER;
                        winner <= 2'b10;
                     end
                  end
               end
               S_OVER: begin
                  state <= S_OVER;
               end
               default: begin
                  state <= S_PLAY;
               end
            endcase
         end
      end
   end

`ifdef RPS_TIE_COUNT_EN
   logic [3:0] tie_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tie_cnt <= 4'd0;
      end else if (clear_game) begin
         tie_cnt <= 4'd0;
      end else if ((state == S_JUDGE) && (judged == RES_TIE)) begin
         tie_cnt <= (tie_cnt == 4'd9) ? 4'd0 : tie_cnt + 4'd1;
      end
   end

   assign tie_count = tie_cnt;
`else
   assign tie_count = 4'b0000;
`endif

endmodule

// File: tb/tb_rps_score_keeper.sv
// Testbench for rps_score_keeper (WIN_SCORE = 5).
// Expected responses come from a match model written in plain arithmetic;
// judged rounds and rejected rounds are queued and checked by a monitor
// whenever the DUT pulses result_valid or round_err.

module tb_rps_score_keeper;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       round_valid = 1'b0;
   logic [1:0] p1_move = 2'b00;
   logic [1:0] p2_move = 2'b00;
   logic       clear_game = 1'b0;
   logic       busy;
   logic       result_valid;
   logic [1:0] round_result;
   logic       round_err;
   logic [3:0] p1_score;
   logic [3:0] p2_score;
   logic [1:0] winner;
   logic       game_over;
   logic [3:0] tie_count;

   rps_score_keeper #(.WIN_SCORE(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .round_valid  (round_valid),
      .p1_move      (p1_move),
      .p2_move      (p2_move),
      .clear_game   (clear_game),
      .busy         (busy),
      .result_valid (result_valid),
      .round_result (round_result),
      .round_err    (round_err),
      .p1_score     (p1_score),
      .p2_score     (p2_score),
      .winner       (winner),
      .game_over    (game_over),
      .tie_count    (tie_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int err;
      int res;
      int s1;
      int s2;
      int win;
      int go;
      int tie;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // match model
   int m_s1, m_s2, m_tie, m_res, m_win;
   int m_over, m_pend, pm1, pm2;

   task automatic chk(input string name, input int got, input int want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_tie = 0; m_res = 0; m_win = 0;
      m_over = 0; m_pend = 0; pm1 = 0; pm2 = 0;
   endtask

   task automatic push_exp(input int is_err);
      exp_t e;
      e.err = is_err; e.res = m_res; e.s1 = m_s1; e.s2 = m_s2;
      e.win = m_win; e.go = m_over; e.tie = m_tie;
      exp_q.push_back(e);
   endtask

   // moves: rock=1 paper=2 scissors=3; each beats the one just below it mod 3
   task automatic model_judge();
      if (pm1 == pm2) begin
         m_res = 3;
`ifdef RPS_TIE_COUNT_EN
         m_tie = (m_tie + 1) % 10;
`endif
      end else if ((pm1 - pm2 + 3) % 3 == 1) begin
         m_res = 1;
         m_s1++;
         if (m_s1 == 5) begin m_over = 1; m_win = 1; end
      end else begin
         m_res = 2;
         m_s2++;
         if (m_s2 == 5) begin m_over = 1; m_win = 2; end
      end
      push_exp(0);
   endtask

   // called just after a rising edge: drive inputs, predict the next edge,
   // advance one clock, then compare the held outputs
   task automatic cycle(input int rv, input int m1, input int m2, input int clr);
      round_valid = rv[0];
      p1_move     = m1[1:0];
      p2_move     = m2[1:0];
      clear_game  = clr[0];
      if (clr != 0) begin
         m_s1 = 0; m_s2 = 0; m_tie = 0; m_res = 0; m_win = 0;
         m_over = 0; m_pend = 0;
      end else if (m_pend != 0) begin
         m_pend = 0;
         model_judge();
      end else if (m_over != 0) begin
         // rounds ignored until clear
      end else if (rv != 0) begin
         if (m1 == 0 || m2 == 0) push_exp(1);
         else begin m_pend = 1; pm1 = m1; pm2 = m2; end
      end
      @(posedge clk);
      #1;
      chk("busy", busy, m_pend);
      chk("game_over", game_over, m_over);
      chk("p1_score", p1_score, m_s1);
      chk("p2_score", p2_score, m_s2);
      chk("winner", winner, m_win);
      chk("round_result", round_result, m_res);
      chk("tie_count", tie_count, m_tie);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_result_valid"}, result_valid, 0);
      chk({tag, "_round_result"}, round_result, 0);
      chk({tag, "_round_err"}, round_err, 0);
      chk({tag, "_p1_score"}, p1_score, 0);
      chk({tag, "_p2_score"}, p2_score, 0);
      chk({tag, "_winner"}, winner, 0);
      chk({tag, "_game_over"}, game_over, 0);
      chk({tag, "_tie_count"}, tie_count, 0);
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (result_valid || round_err) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_pulse", {result_valid, round_err}, 0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_round_err", round_err, e.err);
               chk("sb_result_valid", result_valid, 1 - e.err);
               chk("sb_round_result", round_result, e.res);
               chk("sb_p1_score", p1_score, e.s1);
               chk("sb_p2_score", p2_score, e.s2);
               chk("sb_winner", winner, e.win);
               chk("sb_game_over", game_over, e.go);
               chk("sb_tie_count", tie_count, e.tie);
            end
         end
      end
   end

   initial begin
      int r1, r2;
      model_reset();

      // reset held with garbage moves and a strobe
      round_valid = 1'b1; p1_move = 2'b11; p2_move = 2'b01;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      round_valid = 1'b0; p1_move = 2'b00; p2_move = 2'b00;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset_busy", busy, 0);

      // P1 rock vs P2 scissors until P1 wins
      for (int i = 0; i < 5; i++) begin
         cycle(1, 1, 3, 0);
         cycle(0, 0, 0, 0);
      end
      chk("match_winner", winner, 1);
      chk("match_game_over", game_over, 1);
      chk("match_p2_score", p2_score, 0);
      chk("match_p1_score", p1_score, 5);

      // rounds in OVER are ignored, then clear beats a simultaneous round
      cycle(1, 2, 1, 0);
      cycle(1, 0, 1, 0);
      cycle(1, 1, 3, 1);
      chk("clear_p1_score", p1_score, 0);
      chk("clear_game_over", game_over, 0);
      chk("clear_winner", winner, 0);
      chk("clear_busy", busy, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);

      // eleven ties: paper vs paper
      for (int i = 0; i < 11; i++) begin
         cycle(1, 2, 2, 0);
         cycle(0, 0, 0, 0);
      end
`ifdef RPS_TIE_COUNT_EN
      chk("tie_wrap", tie_count, 1);
`else
      chk("tie_disabled", tie_count, 0);
`endif
      chk("tie_result", round_result, 3);

      // rejected round
      cycle(1, 0, 2, 0);
      cycle(0, 0, 0, 0);

      // strobe held two cycles: P1 rock vs P2 paper counts once
      cycle(1, 1, 2, 0);
      cycle(1, 1, 2, 0);
      cycle(0, 0, 0, 0);
      chk("held_p2_score", p2_score, 1);

      // clear during JUDGE discards the round
      cycle(1, 1, 3, 0);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);

      // reset mid-JUDGE after building some state
      cycle(1, 2, 3, 0);
      cycle(0, 0, 0, 0);
      cycle(1, 3, 1, 0);
      chk("pre_reset_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("mid_judge_reset");
      model_reset();
      round_valid = 1'b0; p1_move = 2'b00; p2_move = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_reset2_busy", busy, 0);

      // random play
      for (int i = 0; i < 600; i++) begin
         r1 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
         r2 = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
         cycle(int'($urandom_range(0, 1)), r1, r2,
               ($urandom_range(0, 39) == 0) ? 1 : 0);
      end

      repeat (3) cycle(0, 0, 0, 0);
      chk("sb_queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
